// File: rtl/tone_mixer_gen.sv
// tone_mixer_gen: multi-voice square-wave tone generator mixed into the codec
// sample stream, with saturation to DATA_W and the Audio_Controller read/write
// handshake.
//
// Optional feature macro: TONE_MIC_MUTE_EN adds a mic_mute input. When it is
// high at the capture edge, the captured codec samples are replaced by zero.
//
// Ports:
//   CLOCK_50, resetn            clock, asynchronous active-low reset
//   voice_en                    per-voice enable
//   period_in / amp_in          per-voice half-period / unsigned amplitude, packed by voice
//   audio_in_available          Audio_Controller has an input sample
//   audio_out_allowed           Audio_Controller can take an output sample
//   left/right_channel_audio_in codec input samples
//   read_audio_in               one-cycle pop strobe
//   write_audio_out             one-cycle push strobe
//   left/right_channel_audio_out mixed, saturated samples
//   busy                        high whenever the sequencer is not idle
module tone_mixer_gen #(
   parameter int unsigned NUM_VOICES = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PERIOD_W   = 19,
   parameter int unsigned AMP_W      = 24
) (
   input  logic                           CLOCK_50,
   input  logic                           resetn,
`ifdef TONE_MIC_MUTE_EN
   input  logic                           mic_mute,
`endif
   input  logic [NUM_VOICES-1:0]          voice_en,
   input  logic [NUM_VOICES*PERIOD_W-1:0] period_in,
   input  logic [NUM_VOICES*AMP_W-1:0]    amp_in,
   input  logic                           audio_in_available,
   input  logic                           audio_out_allowed,
   input  logic [DATA_W-1:0]              left_channel_audio_in,
   input  logic [DATA_W-1:0]              right_channel_audio_in,
   output logic                           read_audio_in,
   output logic                           write_audio_out,
   output logic [DATA_W-1:0]              left_channel_audio_out,
   output logic [DATA_W-1:0]              right_channel_audio_out,
   output logic                           busy
);

   // Tone sum headroom: 8 voices of a DATA_W-bit magnitude fit in DATA_W+4 bits.
   localparam int unsigned SUM_W = DATA_W + 4;
   localparam int unsigned EXT_W = SUM_W - DATA_W;

   localparam logic signed [SUM_W-1:0] SAT_MAX =
      {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN =
      {{(EXT_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MIX   = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   // Per-voice unpacked views of the packed configuration buses.
   logic [PERIOD_W-1:0] period_arr [NUM_VOICES];
   logic [AMP_W-1:0]    amp_arr    [NUM_VOICES];

   always_comb begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         period_arr[v] = period_in[v*PERIOD_W +: PERIOD_W];
         amp_arr[v]    = amp_in[v*AMP_W +: AMP_W];
      end
   end

   // Voice state: half-cycle counter, output phase and the period latched at the last toggle.
   logic [PERIOD_W-1:0]   cnt_q [NUM_VOICES];
   logic [PERIOD_W-1:0]   per_q [NUM_VOICES];
   logic [NUM_VOICES-1:0] phase_q;
   logic [NUM_VOICES-1:0] active_c;

   always_comb begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         active_c[v] = voice_en[v] && (per_q[v] != '0);
      end
   end

   // A new period is only adopted at a toggle (or while idle) so half-waves never glitch.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            cnt_q[v] <= '0;
            per_q[v] <= '0;
         end
         phase_q <= '0;
      end else begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!active_c[v]) begin
               cnt_q[v]   <= '0;
               phase_q[v] <= 1'b0;
               per_q[v]   <= period_arr[v];
            end else if (cnt_q[v] >= per_q[v]) begin
               cnt_q[v]   <= '0;
               phase_q[v] <= ~phase_q[v];
               per_q[v]   <= period_arr[v];
            end else begin
               cnt_q[v]   <= cnt_q[v] + PERIOD_W'(1);
            end
         end
      end
   end

   // Signed sum of the square waves; idle voices contribute nothing.
   logic signed [SUM_W-1:0] tone_sum_c;
   logic signed [SUM_W-1:0] amp_ext_c;

   always_comb begin
      tone_sum_c = '0;
      amp_ext_c  = '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         amp_ext_c = SUM_W'(amp_arr[v]);
         if (active_c[v]) begin
            if (phase_q[v]) tone_sum_c = tone_sum_c + amp_ext_c;
            else            tone_sum_c = tone_sum_c - amp_ext_c;
         end
      end
   end

   // Clamp a widened sum into the DATA_W signed range.
   function automatic logic [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] x);
      if (x > SAT_MAX)      return {1'b0, {(DATA_W - 1){1'b1}}};
      else if (x < SAT_MIN) return {1'b1, {(DATA_W - 1){1'b0}}};
      else                  return x[DATA_W-1:0];
   endfunction

   // Captured transaction operands.
   logic [DATA_W-1:0]       cap_l_q, cap_r_q;
   logic [DATA_W-1:0]       cap_l_d, cap_r_d;
   logic signed [SUM_W-1:0] cap_tone_q;

`ifdef TONE_MIC_MUTE_EN
   assign cap_l_d = mic_mute ? '0 : left_channel_audio_in;
   assign cap_r_d = mic_mute ? '0 : right_channel_audio_in;
`else
   assign cap_l_d = left_channel_audio_in;
   assign cap_r_d = right_channel_audio_in;
`endif

   logic signed [SUM_W-1:0] mix_l_c, mix_r_c;

   always_comb begin
      mix_l_c = $signed({{EXT_W{cap_l_q[DATA_W-1]}}, cap_l_q}) + cap_tone_q;
      mix_r_c = $signed({{EXT_W{cap_r_q[DATA_W-1]}}, cap_r_q}) + cap_tone_q;
   end

   // Handshake sequencer.
   logic [1:0] state_q, state_d;
   logic       read_q, read_d;
   logic       write_q, write_d;
   logic       busy_q, busy_d;
   logic       cap_en_c, out_en_c;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         write_q <= write_d;
         busy_q  <= busy_d;
      end
   end

   // WRITE holds until the push pulse has been issued; the pulse cycle itself returns to IDLE.
   always_comb begin
      state_d  = state_q;
      read_d   = 1'b0;
      write_d  = 1'b0;
      cap_en_c = 1'b0;
      out_en_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (audio_in_available && audio_out_allowed) begin
               state_d  = S_MIX;
               read_d   = 1'b1;
               cap_en_c = 1'b1;
            end
         end
         S_MIX: begin
            out_en_c = 1'b1;
            write_d  = audio_out_allowed;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            if (write_q) state_d = S_IDLE;
            else         write_d = audio_out_allowed;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Capture and output datapath registers.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cap_l_q                 <= '0;
         cap_r_q                 <= '0;
         cap_tone_q              <= '0;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;
      end else begin
         if (cap_en_c) begin
            cap_l_q    <= cap_l_d;
            cap_r_q    <= cap_r_d;
            cap_tone_q <= tone_sum_c;
         end
         if (out_en_c) begin
            left_channel_audio_out  <= saturate(mix_l_c);
            right_channel_audio_out <= saturate(mix_r_c);
         end
      end
   end

   assign read_audio_in   = read_q;
   assign write_audio_out = write_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_tone_mixer_gen.sv
// tb_tone_mixer_gen: directed self-checking bench for tone_mixer_gen.
module tb_tone_mixer_gen;

   logic        CLOCK_50;
   logic        resetn;
   logic        mic_mute;
   logic [1:0]  voice_en;
   logic [37:0] period_in;
   logic [47:0] amp_in;
   logic        audio_in_available;
   logic        audio_out_allowed;
   logic [31:0] left_channel_audio_in;
   logic [31:0] right_channel_audio_in;
   logic        read_audio_in;
   logic        write_audio_out;
   logic [31:0] left_channel_audio_out;
   logic [31:0] right_channel_audio_out;
   logic        busy;

   int n_checks;
   int n_fail;

   tone_mixer_gen dut (
      .CLOCK_50                (CLOCK_50),
      .resetn                  (resetn),
`ifdef TONE_MIC_MUTE_EN
      .mic_mute                (mic_mute),
`endif
      .voice_en                (voice_en),
      .period_in               (period_in),
      .amp_in                  (amp_in),
      .audio_in_available      (audio_in_available),
      .audio_out_allowed       (audio_out_allowed),
      .left_channel_audio_in   (left_channel_audio_in),
      .right_channel_audio_in  (right_channel_audio_in),
      .read_audio_in           (read_audio_in),
      .write_audio_out         (write_audio_out),
      .left_channel_audio_out  (left_channel_audio_out),
      .right_channel_audio_out (right_channel_audio_out),
      .busy                    (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      n_checks++; if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", read_audio_in); end
      n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", write_audio_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (left_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL reset_left: got %h expected 0", left_channel_audio_out); end
      n_checks++; if (right_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL reset_right: got %h expected 0", right_channel_audio_out); end
      resetn = 1'b1;
      tick();
      // Park a transaction in WRITE by withholding audio_out_allowed, then reset.
      left_channel_audio_in  = 32'h12345678;
      right_channel_audio_in = 32'h0BADF00D;
      audio_in_available = 1'b1;
      audio_out_allowed  = 1'b1;
      tick();
      audio_in_available = 1'b0;
      audio_out_allowed  = 1'b0;
      tick();
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwrite_busy: got %b expected 1", busy); end
      n_checks++; if (left_channel_audio_out !== 32'h12345678) begin n_fail++; $display("FAIL midwrite_left: got %h expected 12345678", left_channel_audio_out); end
      resetn = 1'b0;
      #2;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL midreset_write: got %b expected 0", write_audio_out); end
      n_checks++; if (left_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL midreset_left: got %h expected 0", left_channel_audio_out); end
      n_checks++; if (right_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL midreset_right: got %h expected 0", right_channel_audio_out); end
      tick();
      tick();
      resetn = 1'b1;
      audio_out_allowed = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_write: got %b expected 0 at cycle %0d", write_audio_out, i); end
         n_checks++; if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_read: got %b expected 0 at cycle %0d", read_audio_in, i); end
      end
      // Fresh transaction after reset.
      left_channel_audio_in  = 32'h00000055;
      right_channel_audio_in = 32'hFFFFFFAA;
      audio_in_available = 1'b1;
      tick();
      audio_in_available = 1'b0;
      n_checks++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL fresh_read: got %b expected 1", read_audio_in); end
      tick();
      n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL fresh_write: got %b expected 1", write_audio_out); end
      n_checks++; if (left_channel_audio_out !== 32'h00000055) begin n_fail++; $display("FAIL fresh_left: got %h expected 00000055", left_channel_audio_out); end
      n_checks++; if (right_channel_audio_out !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL fresh_right: got %h expected ffffffaa", right_channel_audio_out); end
      tick();
      tick();
   endtask

   // Voice0 period 9, amp 1000; sign flips every 10 clocks. Captures land every 3rd edge.
   task automatic test_tone();
      logic [31:0] tone;
      logic [31:0] exp_l, exp_r;
      voice_en  = 2'b00;
      period_in = {19'd0, 19'd9};
      amp_in    = {24'd0, 24'd1000};
      left_channel_audio_in  = 32'h00010000;
      right_channel_audio_in = 32'hFFFFB000;
      tick();
      voice_en = 2'b01;
      audio_in_available = 1'b1;
      audio_out_allowed  = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k % 3 == 0) begin
            n_checks++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL tone_read k=%0d: got %b expected 1", k, read_audio_in); end
         end else if (k % 3 == 1) begin
            tone  = ((((k - 1) / 10) % 2) == 1) ? 32'd1000 : -32'd1000;
            exp_l = 32'h00010000 + tone;
            exp_r = 32'hFFFFB000 + tone;
            n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL tone_write k=%0d: got %b expected 1", k, write_audio_out); end
            n_checks++; if (left_channel_audio_out !== exp_l) begin n_fail++; $display("FAIL tone_left k=%0d: got %h expected %h", k, left_channel_audio_out, exp_l); end
            n_checks++; if (right_channel_audio_out !== exp_r) begin n_fail++; $display("FAIL tone_right k=%0d: got %h expected %h", k, right_channel_audio_out, exp_r); end
         end
      end
      audio_in_available = 1'b0;
      voice_en = 2'b00;
      repeat (3) tick();
   endtask

   // Period 9 -> 3 written 4 clocks into the second half-wave: that half still lasts 10.
   task automatic test_period_change();
      int          tog [8] = '{9, 19, 23, 27, 31, 35, 39, 43};
      int          nt;
      logic [31:0] tone;
      logic [31:0] exp_l;
      voice_en  = 2'b00;
      period_in = {19'd0, 19'd9};
      amp_in    = {24'd0, 24'd1000};
      left_channel_audio_in  = 32'h00000000;
      right_channel_audio_in = 32'h00000000;
      tick();
      voice_en = 2'b01;
      audio_in_available = 1'b1;
      for (int k = 0; k < 45; k++) begin
         tick();
         if (k == 13) period_in = {19'd0, 19'd3};
         if (k % 3 == 1) begin
            // Captured at edge k-1, which saw the phase left by edge k-2.
            nt = 0;
            for (int t = 0; t < 8; t++) if (tog[t] <= k - 2) nt++;
            tone  = (nt % 2 == 1) ? 32'd1000 : -32'd1000;
            exp_l = tone;
            n_checks++; if (left_channel_audio_out !== exp_l) begin n_fail++; $display("FAIL period_left k=%0d: got %h expected %h", k, left_channel_audio_out, exp_l); end
         end
      end
      audio_in_available = 1'b0;
      voice_en = 2'b00;
      repeat (3) tick();
   endtask

   task automatic test_saturation();
      // Positive: wait for voice0 (period 5, amp 0x1000) to reach phase 1.
      voice_en  = 2'b00;
      period_in = {19'd0, 19'd5};
      amp_in    = {24'd0, 24'h001000};
      tick();
      voice_en = 2'b01;
      repeat (6) tick();
      left_channel_audio_in  = 32'h7FFFFF00;
      right_channel_audio_in = 32'h7FFFEFFF;
      audio_in_available = 1'b1;
      tick();
      audio_in_available = 1'b0;
      n_checks++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL satp_read: got %b expected 1", read_audio_in); end
      tick();
      n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL satp_write: got %b expected 1", write_audio_out); end
      n_checks++; if (left_channel_audio_out !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL satp_left: got %h expected 7fffffff", left_channel_audio_out); end
      n_checks++; if (right_channel_audio_out !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL satp_right_exact: got %h expected 7fffffff", right_channel_audio_out); end
      tick();
      // Negative: a freshly enabled voice sits in phase 0, giving -0x1000.
      voice_en = 2'b00;
      tick();
      voice_en = 2'b01;
      left_channel_audio_in  = 32'h80000100;
      right_channel_audio_in = 32'h80001000;
      audio_in_available = 1'b1;
      tick();
      audio_in_available = 1'b0;
      tick();
      n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL satn_write: got %b expected 1", write_audio_out); end
      n_checks++; if (left_channel_audio_out !== 32'h80000000) begin n_fail++; $display("FAIL satn_left: got %h expected 80000000", left_channel_audio_out); end
      n_checks++; if (right_channel_audio_out !== 32'h80000000) begin n_fail++; $display("FAIL satn_right_exact: got %h expected 80000000", right_channel_audio_out); end
      tick();
      voice_en = 2'b00;
      repeat (2) tick();
   endtask

   task automatic test_backpressure();
      int reads;
      int writes;
      reads  = 0;
      writes = 0;
      voice_en = 2'b00;
      left_channel_audio_in  = 32'hCAFE0001;
      right_channel_audio_in = 32'h00C0FFEE;
      audio_in_available = 1'b1;
      audio_out_allowed  = 1'b1;
      tick();
      reads += int'(read_audio_in);
      writes += int'(write_audio_out);
      n_checks++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL bp_read_t1: got %b expected 1", read_audio_in); end
      audio_out_allowed = 1'b0;
      left_channel_audio_in  = 32'h0;
      right_channel_audio_in = 32'h0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         reads += int'(read_audio_in);
         writes += int'(write_audio_out);
         n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL bp_hold_write i=%0d: got %b expected 0", i, write_audio_out); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold_busy i=%0d: got %b expected 1", i, busy); end
         n_checks++; if (left_channel_audio_out !== 32'hCAFE0001) begin n_fail++; $display("FAIL bp_hold_left i=%0d: got %h expected cafe0001", i, left_channel_audio_out); end
         n_checks++; if (right_channel_audio_out !== 32'h00C0FFEE) begin n_fail++; $display("FAIL bp_hold_right i=%0d: got %h expected 00c0ffee", i, right_channel_audio_out); end
      end
      audio_out_allowed = 1'b1;
      tick();
      reads += int'(read_audio_in);
      writes += int'(write_audio_out);
      n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL bp_release_write: got %b expected 1", write_audio_out); end
      audio_in_available = 1'b0;
      tick();
      reads += int'(read_audio_in);
      writes += int'(write_audio_out);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
      n_checks++; if (reads !== 1) begin n_fail++; $display("FAIL bp_read_count: got %0d expected 1", reads); end
      n_checks++; if (writes !== 1) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 1", writes); end
      tick();
   endtask

   task automatic test_passthrough();
      logic [31:0] l, r;
      voice_en = 2'b00;
      audio_out_allowed = 1'b1;
      for (int s = 0; s < 100; s++) begin
         l = $urandom();
         r = $urandom();
         if (s == 0) begin l = 32'h80000000; r = 32'h7FFFFFFF; end
         left_channel_audio_in  = l;
         right_channel_audio_in = r;
         audio_in_available = 1'b1;
         tick();
         audio_in_available = 1'b0;
         left_channel_audio_in  = ~l;
         right_channel_audio_in = ~r;
         tick();
         n_checks++; if (write_audio_out !== 1'b1) begin n_fail++; $display("FAIL pass_write s=%0d: got %b expected 1", s, write_audio_out); end
         n_checks++; if (left_channel_audio_out !== l) begin n_fail++; $display("FAIL pass_left s=%0d: got %h expected %h", s, left_channel_audio_out, l); end
         n_checks++; if (right_channel_audio_out !== r) begin n_fail++; $display("FAIL pass_right s=%0d: got %h expected %h", s, right_channel_audio_out, r); end
         tick();
      end
`ifdef TONE_MIC_MUTE_EN
      // Muted capture with a freshly enabled voice (phase 0): outputs carry -amp only.
      period_in = {19'd0, 19'd50};
      amp_in    = {24'd0, 24'd777};
      tick();
      voice_en = 2'b01;
      mic_mute = 1'b1;
      left_channel_audio_in  = 32'h11111111;
      right_channel_audio_in = 32'h22222222;
      audio_in_available = 1'b1;
      tick();
      audio_in_available = 1'b0;
      mic_mute = 1'b0;
      n_checks++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL mute_read: got %b expected 1", read_audio_in); end
      tick();
      n_checks++; if (left_channel_audio_out !== -32'd777) begin n_fail++; $display("FAIL mute_left: got %h expected %h", left_channel_audio_out, -32'd777); end
      n_checks++; if (right_channel_audio_out !== -32'd777) begin n_fail++; $display("FAIL mute_right: got %h expected %h", right_channel_audio_out, -32'd777); end
      tick();
      voice_en = 2'b00;
      tick();
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      mic_mute = 1'b0;
      voice_en = 2'b00;
      period_in = '0;
      amp_in    = '0;
      audio_in_available = 1'b0;
      audio_out_allowed  = 1'b1;
      left_channel_audio_in  = '0;
      right_channel_audio_in = '0;
      test_reset();
      test_tone();
      test_period_change();
      test_saturation();
      test_backpressure();
      test_passthrough();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
